// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//   Fetch half of the fetch-decode stage. Owns the PC, issues one
//   instruction-memory request at a time, and presents {instr, pc, valid}
//   to decode. Handles decode back-pressure (stall) and redirects from
//   execute.
//
// Ports
//   i_clk, i_rst       clock, synchronous active-high reset
//   o_imemReq          request to instruction memory
//   o_imemAddr         word-aligned request address, stable until ack
//   i_imemAck          memory returns i_imemData this cycle
//   i_imemData         instruction word, valid with i_imemAck
//   i_redirect         one-cycle pulse: resume fetching at i_redirectPc
//   i_redirectPc       redirect target (low two bits forced to 0)
//   i_stall            decode cannot accept the held instruction
//   o_instrValid       o_instr/o_pc hold a valid fetched instruction
//   o_instr, o_pc      fetched instruction and its address
//   o_misaligned       pulse: previous cycle's redirect target was unaligned
//   dbg_state          current FSM state (FETCH=0, VALID=1, DRAIN=2)
//
// Memory handshake (valid/ready style):
//   The request is offered while o_imemReq=1 and o_imemAddr is held stable
//   until the memory acknowledges. A transfer completes at the rising edge
//   where o_imemReq and i_imemAck are both 1; ack in the same cycle the
//   request rises is legal. i_imemAck is ignored while o_imemReq=0.
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemAck,
  input  logic [31:0] i_imemData,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  input  logic        i_stall,
  output logic        o_instrValid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_misaligned,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] VALID = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pending;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        misaligned_q;

  logic [31:0] redirect_tgt;
  logic        ack_taken;

  assign redirect_tgt = {i_redirectPc[31:2], 2'b00};

  // The request is masked while reset is asserted so a request is never
  // offered in a cycle whose edge will discard it.
  assign o_imemReq  = (state != VALID) && !i_rst;
  // In DRAIN pc still holds the abandoned address, so the address stays
  // stable until the outstanding request is acknowledged.
  assign o_imemAddr = pc;
  assign ack_taken  = o_imemReq && i_imemAck;

  assign o_instrValid = valid_q;
  assign o_instr      = instr_q;
  assign o_pc         = pc_q;
  assign o_misaligned = misaligned_q;
  assign dbg_state    = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      pending      <= 32'h0;
      instr_q      <= 32'h0;
      pc_q         <= 32'h0;
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= i_redirect && (i_redirectPc[1:0] != 2'b00);
      case (state)
        FETCH: begin
          if (ack_taken && !i_redirect) begin
            instr_q <= i_imemData;
            pc_q    <= pc;
            valid_q <= 1'b1;
            state   <= VALID;
          end else if (ack_taken && i_redirect) begin
            // Returned data belongs to the squashed path.
            pc <= redirect_tgt;
          end else if (i_redirect) begin
            // The old request must still complete before the new one starts.
            pending <= redirect_tgt;
            state   <= DRAIN;
          end
        end
        VALID: begin
          if (i_redirect) begin
            valid_q <= 1'b0;
            pc      <= redirect_tgt;
            state   <= FETCH;
          end else if (!i_stall) begin
            valid_q <= 1'b0;
            pc      <= pc + 32'd4;
            state   <= FETCH;
          end
        end
        DRAIN: begin
          if (ack_taken) begin
            pc    <= i_redirect ? redirect_tgt : pending;
            state <= FETCH;
          end else if (i_redirect) begin
            pending <= redirect_tgt;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state   <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer (RESET_PC = 0x100). Inputs change
//   just after the falling edge; outputs are checked 1 ns later, so every
//   check sees the state produced by the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        i_clk;
  logic        i_rst;
  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemData;
  logic        i_redirect;
  logic [31:0] i_redirectPc;
  logic        i_stall;
  logic        o_instrValid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_misaligned;
  logic [1:0]  dbg_state;

  int total;
  int bad;

  fetch_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .o_imemReq    (o_imemReq),
    .o_imemAddr   (o_imemAddr),
    .i_imemAck    (i_imemAck),
    .i_imemData   (i_imemData),
    .i_redirect   (i_redirect),
    .i_redirectPc (i_redirectPc),
    .i_stall      (i_stall),
    .o_instrValid (o_instrValid),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_misaligned (o_misaligned),
    .dbg_state    (dbg_state)
  );

  // clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ack, input logic [31:0] data,
                       input logic redir, input logic [31:0] rpc,
                       input logic stall);
    i_imemAck    = ack;
    i_imemData   = data;
    i_redirect   = redir;
    i_redirectPc = rpc;
    i_stall      = stall;
  endtask

  task automatic next_cycle();
    @(negedge i_clk);
  endtask

  // Leaves the bench just after a falling edge, in the first cycle after
  // reset drops, inputs idle.
  task automatic do_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    i_rst = 1'b1;
    next_cycle();
    next_cycle();
    i_rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    i_rst = 1'b1;
    next_cycle();
    next_cycle();
    #1;
    total++; if (o_imemReq !== 1'b0) begin bad++; $display("FAIL rst_req got=%0h want=0", o_imemReq); end
    total++; if (o_instrValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", o_instrValid); end
    total++; if (o_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%08h want=00000000", o_instr); end
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%08h want=00000000", o_pc); end
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL rst_misaligned got=%0h want=0", o_misaligned); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
    i_rst = 1'b0;
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h100) begin bad++; $display("FAIL rst_first_req got=%0h@%08h want=1@00000100", o_imemReq, o_imemAddr); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    drive(1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h100) begin bad++; $display("FAIL zw_req got=%0h@%08h want=1@00000100", o_imemReq, o_imemAddr); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_instrValid !== 1'b1 || o_pc !== 32'h100 || o_instr !== 32'h0050_0093) begin bad++; $display("FAIL zw_valid got=%0h pc=%08h instr=%08h want=1 pc=00000100 instr=00500093", o_instrValid, o_pc, o_instr); end
    total++; if (o_imemReq !== 1'b0) begin bad++; $display("FAIL zw_noreq got=%0h want=0", o_imemReq); end
    next_cycle();
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h104 || o_instrValid !== 1'b0) begin bad++; $display("FAIL zw_next got=%0h@%08h v=%0h want=1@00000104 v=0", o_imemReq, o_imemAddr, o_instrValid); end
  endtask

  task automatic test_wait_stall();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive((c == 2), 32'h00a0_0113, 1'b0, 32'h0, 1'b0);
      #1;
      total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h100 || o_instrValid !== 1'b0) begin bad++; $display("FAIL ws_hold%0d got=%0h@%08h v=%0h want=1@00000100 v=0", c, o_imemReq, o_imemAddr, o_instrValid); end
      next_cycle();
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, (c < 2));
      #1;
      total++; if (o_instrValid !== 1'b1 || o_instr !== 32'h00a0_0113 || o_pc !== 32'h100) begin bad++; $display("FAIL ws_held%0d got v=%0h instr=%08h pc=%08h want v=1 instr=00a00113 pc=00000100", c, o_instrValid, o_instr, o_pc); end
      total++; if (o_imemReq !== 1'b0) begin bad++; $display("FAIL ws_noreq%0d got=%0h want=0", c, o_imemReq); end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h104 || o_instrValid !== 1'b0) begin bad++; $display("FAIL ws_next got=%0h@%08h v=%0h want=1@00000104 v=0", o_imemReq, o_imemAddr, o_instrValid); end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h100 || o_instrValid !== 1'b0) begin bad++; $display("FAIL rp_drain got=%0h@%08h v=%0h want=1@00000100 v=0", o_imemReq, o_imemAddr, o_instrValid); end
    next_cycle();
    drive(1'b1, 32'hdead_beef, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemAddr !== 32'h100) begin bad++; $display("FAIL rp_ackaddr got=%08h want=00000100", o_imemAddr); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h200 || o_instrValid !== 1'b0) begin bad++; $display("FAIL rp_new got=%0h@%08h v=%0h want=1@00000200 v=0", o_imemReq, o_imemAddr, o_instrValid); end
  endtask

  task automatic test_redirect_valid_stall();
    do_reset();
    drive(1'b1, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    total++; if (o_instrValid !== 1'b1) begin bad++; $display("FAIL rv_valid got=%0h want=1", o_instrValid); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 32'h300, 1'b1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #1;
    total++; if (o_instrValid !== 1'b0 || o_imemReq !== 1'b1 || o_imemAddr !== 32'h300) begin bad++; $display("FAIL rv_redir got v=%0h %0h@%08h want v=0 1@00000300", o_instrValid, o_imemReq, o_imemAddr); end
  endtask

  task automatic test_misaligned_drain();
    do_reset();
    drive(1'b1, 32'h2222_2222, 1'b1, 32'h202, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_misaligned !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%0h want=1", o_misaligned); end
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h200 || o_instrValid !== 1'b0) begin bad++; $display("FAIL mis_fetch got=%0h@%08h v=%0h want=1@00000200 v=0", o_imemReq, o_imemAddr, o_instrValid); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 32'h400, 1'b0);
    #1;
    total++; if (o_misaligned !== 1'b0) begin bad++; $display("FAIL mis_oneshot got=%0h want=0", o_misaligned); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    #1;
    total++; if (o_misaligned !== 1'b0 || o_imemAddr !== 32'h200) begin bad++; $display("FAIL dr_first got mis=%0h addr=%08h want mis=0 addr=00000200", o_misaligned, o_imemAddr); end
    next_cycle();
    drive(1'b1, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemAddr !== 32'h200 || o_instrValid !== 1'b0) begin bad++; $display("FAIL dr_ack got addr=%08h v=%0h want addr=00000200 v=0", o_imemAddr, o_instrValid); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h500 || o_instrValid !== 1'b0) begin bad++; $display("FAIL dr_latest got=%0h@%08h v=%0h want=1@00000500 v=0", o_imemReq, o_imemAddr, o_instrValid); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    drive(1'b0, 32'h0, 1'b1, 32'h600, 1'b0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    i_rst = 1'b1;
    #1;
    total++; if (o_imemReq !== 1'b0) begin bad++; $display("FAIL rd_req0 got=%0h want=0", o_imemReq); end
    next_cycle();
    drive(1'b1, 32'h4444_4444, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b0) begin bad++; $display("FAIL rd_req1 got=%0h want=0", o_imemReq); end
    next_cycle();
    i_rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h100 || o_instrValid !== 1'b0) begin bad++; $display("FAIL rd_restart got=%0h@%08h v=%0h want=1@00000100 v=0", o_imemReq, o_imemAddr, o_instrValid); end
    next_cycle();
    #1;
    total++; if (o_imemAddr !== 32'h100 || o_instrValid !== 1'b0 || o_instr !== 32'h0) begin bad++; $display("FAIL rd_ignored got addr=%08h v=%0h instr=%08h want addr=00000100 v=0 instr=00000000", o_imemAddr, o_instrValid, o_instr); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    drive(1'b1, 32'h0, 1'b1, 32'hffff_fffc, 1'b0);
    next_cycle();
    drive(1'b1, 32'h5555_5555, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_imemAddr !== 32'hffff_fffc) begin bad++; $display("FAIL wrap_addr got=%08h want=fffffffc", o_imemAddr); end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    total++; if (o_instrValid !== 1'b1 || o_pc !== 32'hffff_fffc || o_instr !== 32'h5555_5555) begin bad++; $display("FAIL wrap_valid got v=%0h pc=%08h instr=%08h want v=1 pc=fffffffc instr=55555555", o_instrValid, o_pc, o_instr); end
    next_cycle();
    #1;
    total++; if (o_imemReq !== 1'b1 || o_imemAddr !== 32'h0) begin bad++; $display("FAIL wrap_next got=%0h@%08h want=1@00000000", o_imemReq, o_imemAddr); end
  endtask

  // Memory acks every cycle: one instruction every two cycles.
  task automatic test_back_to_back();
    int n_valid;
    logic [31:0] exp_pc;
    do_reset();
    n_valid = 0;
    exp_pc = 32'h100;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 32'h0000_1000 + c, 1'b0, 32'h0, 1'b0);
      #1;
      if (o_instrValid === 1'b1) begin
        total++; if (o_pc !== exp_pc) begin bad++; $display("FAIL b2b_pc got=%08h want=%08h", o_pc, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        n_valid++;
      end
      next_cycle();
    end
    total++; if (n_valid != 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", n_valid); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    i_rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge i_clk);
    test_reset();
    test_zero_wait();
    test_wait_stall();
    test_redirect_pending();
    test_redirect_valid_stall();
    test_misaligned_drain();
    test_reset_in_drain();
    test_pc_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
